dmi_access_ctrl: RTL and testbench

Upstream neighbour of the debug-module wrapper: turns JTAG DTM `dmi` register update/capture events into single-outstanding DMI request/response transactions toward the debug module. Holds the sticky `dmistat` error state and the capture value shifted back to the debugger. Runs on the DTM clock; the DM side consumes `dmi_req_*` and produces `dmi_resp_*`.

---
 rtl/dmi_access_ctrl_pkg.sv | 33 +++
 rtl/dmi_access_ctrl.sv | 177 +++++++++++++++++
 tb/tb_dmi_access_ctrl.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmi_access_ctrl_pkg.sv
// Shared debug package for the DTM-side DMI access controller.
// Holds the DMI op encodings, DM response codes, dmistat codes, the
// controller state enum and the default DMI address width.
package dmi_access_ctrl_pkg;

    localparam int unsigned ABITS_DEFAULT = 7;

    // DMI op field encodings (as shifted in by the debugger)
    localparam logic [1:0] OP_NOP      = 2'd0;
    localparam logic [1:0] OP_READ     = 2'd1;
    localparam logic [1:0] OP_WRITE    = 2'd2;
    localparam logic [1:0] OP_RESERVED = 2'd3;

    // Debug-module response codes
    localparam logic [1:0] RESP_SUCCESS = 2'd0;

    // Sticky dmistat codes
    localparam logic [1:0] STAT_OK     = 2'd0;
    localparam logic [1:0] STAT_FAILED = 2'd2;
    localparam logic [1:0] STAT_BUSY   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } dmi_state_e;

    // True for ops that start a DMI transaction
    function automatic logic op_is_access(input logic [1:0] op);
        return (op == OP_READ) || (op == OP_WRITE);
    endfunction

endpackage

// File: rtl/dmi_access_ctrl.sv
// DMI access controller: converts JTAG DTM dmi Update-DR / Capture-DR
// events into single-outstanding DMI request/response transactions and
// keeps the sticky dmistat state plus the capture value.
// Ports:
//   clock, reset_n               DTM clock, async active-low reset
//   upd_valid/addr/data/op       Update-DR event with shifted fields
//   cap_valid, cap_value         Capture-DR event, value to shift out
//   dmireset, dmihardreset       dtmcs clear / hard-reset pulses
//   dmistat                      sticky status (0 ok, 2 failed, 3 busy)
//   dmi_req_*                    request channel toward the DM
//   dmi_resp_*                   response channel from the DM
module dmi_access_ctrl
    import dmi_access_ctrl_pkg::*;
#(
    parameter int unsigned ABITS = ABITS_DEFAULT
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             upd_valid,
    input  logic [ABITS-1:0] upd_addr,
    input  logic [31:0]      upd_data,
    input  logic [1:0]       upd_op,
    input  logic             cap_valid,
    output logic [ABITS+33:0] cap_value,
    input  logic             dmireset,
    input  logic             dmihardreset,
    output logic [1:0]       dmistat,
    output logic             dmi_req_valid,
    input  logic             dmi_req_ready,
    output logic [ABITS-1:0] dmi_req_addr,
    output logic [31:0]      dmi_req_data,
    output logic [1:0]       dmi_req_op,
    input  logic             dmi_resp_valid,
    output logic             dmi_resp_ready,
    input  logic [31:0]      dmi_resp_data,
    input  logic [1:0]       dmi_resp_resp
);

    dmi_state_e        state_q, state_d;
    logic              req_valid_q, req_valid_d;
    logic [ABITS-1:0]  req_addr_q, req_addr_d;
    logic [31:0]       req_data_q, req_data_d;
    logic [1:0]        req_op_q, req_op_d;
    logic [31:0]       resp_data_q, resp_data_d;
    logic [1:0]        dmistat_q, dmistat_d;
    logic [ABITS+33:0] cap_value_q, cap_value_d;
    logic              resp_ready_q, resp_ready_d;

    // Next-state, transaction and sticky-status logic
    always_comb begin
        state_d      = state_q;
        req_valid_d  = req_valid_q;
        req_addr_d   = req_addr_q;
        req_data_d   = req_data_q;
        req_op_d     = req_op_q;
        resp_data_d  = resp_data_q;
        dmistat_d    = dmistat_q;
        cap_value_d  = cap_value_q;
        resp_ready_d = resp_ready_q;

        if (dmihardreset) begin
            // Hard reset overrides every other event this cycle
            state_d      = ST_IDLE;
            req_valid_d  = 1'b0;
            dmistat_d    = STAT_OK;
            resp_ready_d = 1'b1;
        end else begin
            // dmireset is applied before the update is evaluated
            if (dmireset) begin
                dmistat_d = STAT_OK;
            end else begin
                dmistat_d = dmistat_q;
            end

            case (state_q)
                ST_IDLE: begin
                    // Stray responses are accepted here and discarded
                    if (upd_valid && (dmistat_d == STAT_OK) && op_is_access(upd_op)) begin
                        req_addr_d  = upd_addr;
                        req_data_d  = upd_data;
                        req_op_d    = upd_op;
                        req_valid_d = 1'b1;
                        state_d     = ST_REQ;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_REQ: begin
                    // An overlapping update is dropped; the in-flight request stays
                    if (upd_valid) begin
                        dmistat_d = STAT_BUSY;
                    end else begin
                        dmistat_d = dmistat_d;
                    end
                    if (dmi_req_ready) begin
                        req_valid_d = 1'b0;
                        state_d     = ST_RESP;
                    end else begin
                        state_d = ST_REQ;
                    end
                end
                ST_RESP: begin
                    if (upd_valid) begin
                        dmistat_d = STAT_BUSY;
                    end else begin
                        dmistat_d = dmistat_d;
                    end
                    if (dmi_resp_valid) begin
                        resp_data_d = dmi_resp_data;
                        // Busy is never downgraded to failed
                        if ((dmi_resp_resp != RESP_SUCCESS) && (dmistat_d != STAT_BUSY)) begin
                            dmistat_d = STAT_FAILED;
                        end else begin
                            dmistat_d = dmistat_d;
                        end
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_RESP;
                    end
                end
                default: begin
                    state_d     = ST_IDLE;
                    req_valid_d = 1'b0;
                end
            endcase

            // Capture uses the pre-response data register, so a response
            // landing in the same cycle is reported on the next capture
            if (cap_valid) begin
                if (state_q == ST_IDLE) begin
                    cap_value_d = {req_addr_q, resp_data_q, dmistat_d};
                end else begin
                    dmistat_d   = STAT_BUSY;
                    cap_value_d = {req_addr_q, resp_data_q, OP_RESERVED};
                end
            end else begin
                cap_value_d = cap_value_q;
            end

            resp_ready_d = (state_d != ST_REQ);
        end
    end

    // State and output registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            req_valid_q  <= 1'b0;
            req_addr_q   <= {ABITS{1'b0}};
            req_data_q   <= 32'd0;
            req_op_q     <= 2'd0;
            resp_data_q  <= 32'd0;
            dmistat_q    <= STAT_OK;
            cap_value_q  <= {(ABITS+34){1'b0}};
            resp_ready_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            req_valid_q  <= req_valid_d;
            req_addr_q   <= req_addr_d;
            req_data_q   <= req_data_d;
            req_op_q     <= req_op_d;
            resp_data_q  <= resp_data_d;
            dmistat_q    <= dmistat_d;
            cap_value_q  <= cap_value_d;
            resp_ready_q <= resp_ready_d;
        end
    end

    assign dmi_req_valid  = req_valid_q;
    assign dmi_req_addr   = req_addr_q;
    assign dmi_req_data   = req_data_q;
    assign dmi_req_op     = req_op_q;
    assign dmistat        = dmistat_q;
    assign cap_value      = cap_value_q;
    assign dmi_resp_ready = resp_ready_q;

endmodule

// File: tb/tb_dmi_access_ctrl.sv
// Directed testbench for dmi_access_ctrl with an expected-value queue.
module tb_dmi_access_ctrl;

    localparam int AB = 7;

    logic            clock;
    logic            reset_n;
    logic            upd_valid;
    logic [AB-1:0]   upd_addr;
    logic [31:0]     upd_data;
    logic [1:0]      upd_op;
    logic            cap_valid;
    logic [AB+33:0]  cap_value;
    logic            dmireset;
    logic            dmihardreset;
    logic [1:0]      dmistat;
    logic            dmi_req_valid;
    logic            dmi_req_ready;
    logic [AB-1:0]   dmi_req_addr;
    logic [31:0]     dmi_req_data;
    logic [1:0]      dmi_req_op;
    logic            dmi_resp_valid;
    logic            dmi_resp_ready;
    logic [31:0]     dmi_resp_data;
    logic [1:0]      dmi_resp_resp;

    int checks;
    int failures;

    typedef struct {
        string       tag;
        logic [63:0] val;
    } exp_t;
    exp_t sb[$];

    dmi_access_ctrl #(.ABITS(AB)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .upd_valid      (upd_valid),
        .upd_addr       (upd_addr),
        .upd_data       (upd_data),
        .upd_op         (upd_op),
        .cap_valid      (cap_valid),
        .cap_value      (cap_value),
        .dmireset       (dmireset),
        .dmihardreset   (dmihardreset),
        .dmistat        (dmistat),
        .dmi_req_valid  (dmi_req_valid),
        .dmi_req_ready  (dmi_req_ready),
        .dmi_req_addr   (dmi_req_addr),
        .dmi_req_data   (dmi_req_data),
        .dmi_req_op     (dmi_req_op),
        .dmi_resp_valid (dmi_resp_valid),
        .dmi_resp_ready (dmi_resp_ready),
        .dmi_resp_data  (dmi_resp_data),
        .dmi_resp_resp  (dmi_resp_resp)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic push(input string tag, input logic [63:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    // Pop the oldest expectation and compare against the observed value
    task automatic check(input logic [63:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $error("FAIL scoreboard_empty observed=%h", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                failures++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_upd(input logic [AB-1:0] a, input logic [31:0] d, input logic [1:0] op);
        upd_addr  = a;
        upd_data  = d;
        upd_op    = op;
        upd_valid = 1'b1;
        tick();
        upd_valid = 1'b0;
    endtask

    task automatic do_cap();
        cap_valid = 1'b1;
        tick();
        cap_valid = 1'b0;
    endtask

    task automatic do_handshake();
        dmi_req_ready = 1'b1;
        tick();
        dmi_req_ready = 1'b0;
    endtask

    task automatic do_resp(input logic [31:0] d, input logic [1:0] r);
        dmi_resp_data  = d;
        dmi_resp_resp  = r;
        dmi_resp_valid = 1'b1;
        tick();
        dmi_resp_valid = 1'b0;
    endtask

    task automatic check_reset_values(input string pfx);
        push({pfx, "_req_valid"}, 64'd0);   check({63'd0, dmi_req_valid});
        push({pfx, "_req_addr"}, 64'd0);    check({57'd0, dmi_req_addr});
        push({pfx, "_req_data"}, 64'd0);    check({32'd0, dmi_req_data});
        push({pfx, "_req_op"}, 64'd0);      check({62'd0, dmi_req_op});
        push({pfx, "_dmistat"}, 64'd0);     check({62'd0, dmistat});
        push({pfx, "_cap_value"}, 64'd0);   check({23'd0, cap_value});
        push({pfx, "_resp_ready"}, 64'd1);  check({63'd0, dmi_resp_ready});
    endtask

    function automatic logic [63:0] capv(input logic [6:0] a, input logic [31:0] d, input logic [1:0] s);
        return {23'd0, a, d, s};
    endfunction

    initial begin
        checks         = 0;
        failures       = 0;
        reset_n        = 1'b0;
        upd_valid      = 1'b0;
        upd_addr       = 7'd0;
        upd_data       = 32'd0;
        upd_op         = 2'd0;
        cap_valid      = 1'b0;
        dmireset       = 1'b0;
        dmihardreset   = 1'b0;
        dmi_req_ready  = 1'b0;
        dmi_resp_valid = 1'b0;
        dmi_resp_data  = 32'd0;
        dmi_resp_resp  = 2'd0;

        repeat (3) tick();
        check_reset_values("reset");
        reset_n = 1'b1;
        tick();

        // Write transaction
        do_upd(7'h10, 32'h1, 2'd2);
        push("wr_req_valid", 64'd1);       check({63'd0, dmi_req_valid});
        push("wr_req_addr", 64'h10);       check({57'd0, dmi_req_addr});
        push("wr_req_data", 64'h1);        check({32'd0, dmi_req_data});
        push("wr_req_op", 64'd2);          check({62'd0, dmi_req_op});
        do_handshake();
        push("wr_req_drop", 64'd0);        check({63'd0, dmi_req_valid});
        push("wr_resp_ready", 64'd1);      check({63'd0, dmi_resp_ready});
        do_resp(32'h0, 2'd0);
        push("wr_dmistat", 64'd0);         check({62'd0, dmistat});
        do_cap();
        push("wr_cap", capv(7'h10, 32'h0, 2'd0)); check({23'd0, cap_value});

        // Read transaction
        do_upd(7'h11, 32'h0, 2'd1);
        push("rd_req_op", 64'd1);          check({62'd0, dmi_req_op});
        do_handshake();
        do_resp(32'h00030382, 2'd0);
        do_cap();
        push("rd_cap", capv(7'h11, 32'h00030382, 2'd0)); check({23'd0, cap_value});

        // nop and reserved ops start nothing
        do_upd(7'h22, 32'h5, 2'd0);
        push("nop_no_req", 64'd0);         check({63'd0, dmi_req_valid});
        do_upd(7'h23, 32'h6, 2'd3);
        push("rsv_no_req", 64'd0);         check({63'd0, dmi_req_valid});

        // Busy: DM stalls, capture mid-wait
        do_upd(7'h12, 32'hAA, 2'd2);
        tick();
        tick();
        do_cap();
        push("busy_cap", capv(7'h12, 32'h00030382, 2'd3)); check({23'd0, cap_value});
        push("busy_dmistat", 64'd3);       check({62'd0, dmistat});
        tick();
        tick();
        push("busy_req_hold", 64'd1);      check({63'd0, dmi_req_valid});
        push("busy_addr_hold", 64'h12);    check({57'd0, dmi_req_addr});
        do_handshake();
        do_resp(32'h0, 2'd0);
        push("busy_sticky", 64'd3);        check({62'd0, dmistat});
        do_upd(7'h13, 32'h0, 2'd1);
        push("busy_upd_ignored", 64'd0);   check({63'd0, dmi_req_valid});
        dmireset = 1'b1;
        tick();
        dmireset = 1'b0;
        push("busy_dmireset", 64'd0);      check({62'd0, dmistat});

        // Failure response
        do_upd(7'h14, 32'h0, 2'd1);
        do_handshake();
        do_resp(32'h00000BAD, 2'd2);
        push("fail_dmistat", 64'd2);       check({62'd0, dmistat});
        do_cap();
        push("fail_cap", capv(7'h14, 32'h00000BAD, 2'd2)); check({23'd0, cap_value});
        do_upd(7'h15, 32'h0, 2'd1);
        push("fail_upd_ignored", 64'd0);   check({63'd0, dmi_req_valid});

        // dmireset and update together: update sees a cleared status
        dmireset = 1'b1;
        do_upd(7'h17, 32'h0, 2'd1);
        dmireset = 1'b0;
        push("rst_upd_req", 64'd1);        check({63'd0, dmi_req_valid});
        push("rst_upd_addr", 64'h17);      check({57'd0, dmi_req_addr});
        push("rst_upd_stat", 64'd0);       check({62'd0, dmistat});
        do_handshake();

        // Capture and failing response in the same RESP cycle
        cap_valid = 1'b1;
        do_resp(32'h00001234, 2'd2);
        cap_valid = 1'b0;
        push("caprsp_dmistat", 64'd3);     check({62'd0, dmistat});
        push("caprsp_cap", capv(7'h17, 32'h00000BAD, 2'd3)); check({23'd0, cap_value});
        do_cap();
        push("caprsp_data", capv(7'h17, 32'h00001234, 2'd3)); check({23'd0, cap_value});
        dmireset = 1'b1;
        tick();
        dmireset = 1'b0;
        push("caprsp_clear", 64'd0);       check({62'd0, dmistat});

        // Hard reset while awaiting a response, then a late response
        do_upd(7'h15, 32'h55, 2'd2);
        do_handshake();
        do_upd(7'h18, 32'h0, 2'd1);
        push("hr_pre_busy", 64'd3);        check({62'd0, dmistat});
        dmihardreset = 1'b1;
        tick();
        dmihardreset = 1'b0;
        push("hr_dmistat", 64'd0);         check({62'd0, dmistat});
        push("hr_req_valid", 64'd0);       check({63'd0, dmi_req_valid});
        push("hr_resp_ready", 64'd1);      check({63'd0, dmi_resp_ready});
        do_resp(32'h0000DEAD, 2'd0);
        do_cap();
        push("hr_stray_cap", capv(7'h15, 32'h00001234, 2'd0)); check({23'd0, cap_value});

        // Hard reset while a request is presented
        do_upd(7'h19, 32'h0, 2'd1);
        push("hrq_req_valid", 64'd1);      check({63'd0, dmi_req_valid});
        dmihardreset  = 1'b1;
        dmi_req_ready = 1'b0;
        tick();
        dmihardreset = 1'b0;
        push("hrq_req_drop", 64'd0);       check({63'd0, dmi_req_valid});

        // Async reset with a request presented
        do_upd(7'h16, 32'h77, 2'd2);
        push("ar_req_valid", 64'd1);       check({63'd0, dmi_req_valid});
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_values("async");
        tick();
        reset_n = 1'b1;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
